educ8_tstate_seq: RTL and testbench

- Front-panel run/stop/single-step controller and T-state sequencer for the EDUC-8 timing chain.
- Produces the 4-bit T-state code and advance gate that feed the 74154-style 4-to-16 state decoder downstream.
- Replaces the bare 74161 free-run arrangement: the counter now advances only under panel or CPU control, and always stops on a machine-cycle boundary.

---
 rtl/educ8_pkg.sv | 23 ++
 rtl/educ8_sw_sync.sv | 34 +++
 rtl/educ8_tstate_seq.sv | 108 ++++++++++
 tb/tb_educ8_tstate_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/educ8_pkg.sv
// Shared definitions for the EDUC-8 timing chain.
// Contents:
//   TS_W    - width of the T-state code fed to the 4-to-16 state decoder
//   mode_e  - sequencer mode encoding (HALT/RUN/STOPPING/STEP)
//   ts_next - wrapping T-state increment
package educ8_pkg;

  localparam int unsigned TS_W = 4;

  typedef enum logic [1:0] {
    ModeHalt     = 2'd0,
    ModeRun      = 2'd1,
    ModeStopping = 2'd2,
    ModeStep     = 2'd3
  } mode_e;

  // Next T-state code: wraps to 0 after the last state of the machine cycle.
  function automatic logic [TS_W-1:0] ts_next(input logic [TS_W-1:0] ts,
                                              input logic [TS_W-1:0] last);
    return (ts == last) ? '0 : ts + TS_W'(1);
  endfunction

endpackage

// File: rtl/educ8_sw_sync.sv
// Panel switch synchroniser and rising-edge detector.
// Ports:
//   clk   - system clock
//   nclr  - asynchronous active-low reset; clears the chain and edge history
//   sw    - asynchronous, level-sensitive panel switch
//   pulse - one-clock pulse on each synchronised rising edge of sw
// The pulse is decoded from flops only, so it is glitch-free; the FSM that
// consumes it acts on the following edge, SYNC_STAGES+1 clocks after sw rises.
module educ8_sw_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nclr,
  input  logic sw,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A held level leaves sync and history equal, so it never retriggers.
  assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/educ8_tstate_seq.sv
// EDUC-8 front-panel run/stop/single-step controller and T-state sequencer.
// Ports:
//   clk       - system clock, all state changes on the rising edge
//   nclr      - asynchronous active-low reset
//   run_sw    - panel RUN switch (async level)
//   stop_sw   - panel STOP switch (async level)
//   step_sw   - panel SINGLE-STEP switch (async level)
//   halt_req  - CPU HLT decode, sampled on the last T-state while running
//   tstate    - current T-state code, 0..NSTATES-1
//   adv       - tstate advances at the end of this clock
//   cycle_end - adv with tstate at the last state of the machine cycle
//   running   - mode is not HALT (panel RUN lamp)
// The counter only stops on the wrap to T0, so HALT is always entered at T0.
module educ8_tstate_seq import educ8_pkg::*; #(
  parameter int unsigned NSTATES     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            nclr,
  input  logic            run_sw,
  input  logic            stop_sw,
  input  logic            step_sw,
  input  logic            halt_req,
  output logic [TS_W-1:0] tstate,
  output logic            adv,
  output logic            cycle_end,
  output logic            running
);

  localparam logic [TS_W-1:0] LastTs = TS_W'(NSTATES - 1);

  logic run_e, stop_e, step_e;

  educ8_sw_sync #(.SYNC_STAGES(SYNC_STAGES)) u_run_sync (
    .clk  (clk),
    .nclr (nclr),
    .sw   (run_sw),
    .pulse(run_e)
  );

  educ8_sw_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
    .clk  (clk),
    .nclr (nclr),
    .sw   (stop_sw),
    .pulse(stop_e)
  );

  educ8_sw_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk  (clk),
    .nclr (nclr),
    .sw   (step_sw),
    .pulse(step_e)
  );

  mode_e           mode_q, mode_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            active_q;    // registered "mode_d != HALT"; drives adv and running
  logic            cycle_end_q;
  logic            wrap;

  always_comb begin
    mode_d = mode_q;
    ts_d   = active_q ? ts_next(ts_q, LastTs) : ts_q;
    wrap   = active_q && (ts_q == LastTs);
    case (mode_q)
      ModeHalt: begin
        if (run_e) begin
          mode_d = ModeRun;
        end else if (step_e) begin
          mode_d = ModeStep;
        end
      end
      ModeRun: begin
        // A stop request landing on the wrap itself finishes this cycle and
        // halts, rather than running one more cycle in STOPPING.
        if (stop_e || (halt_req && (ts_q == LastTs))) begin
          mode_d = wrap ? ModeHalt : ModeStopping;
        end
      end
      ModeStopping, ModeStep: begin
        if (wrap) begin
          mode_d = ModeHalt;
        end
      end
      default: mode_d = ModeHalt;
    endcase
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      mode_q      <= ModeHalt;
      ts_q        <= '0;
      active_q    <= 1'b0;
      cycle_end_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      ts_q        <= ts_d;
      active_q    <= (mode_d != ModeHalt);
      cycle_end_q <= (mode_d != ModeHalt) && (ts_d == LastTs);
    end
  end

  assign tstate    = ts_q;
  assign adv       = active_q;
  assign running   = active_q;
  assign cycle_end = cycle_end_q;

endmodule

// File: tb/tb_educ8_tstate_seq.sv
// Bench for educ8_tstate_seq: an NSTATES=8 instance driven from a vector table
// plus directed sequences, and an NSTATES=5 instance for edge-priority cases.
module tb_educ8_tstate_seq;

  logic       clk;
  logic       nclr;
  logic       run8, stop8, step8, halt8;
  logic [3:0] ts8;
  logic       adv8, ce8, rn8;
  logic       run5, stop5, step5, halt5;
  logic [3:0] ts5;
  logic       adv5, ce5, rn5;

  int checks;
  int errors;

  educ8_tstate_seq #(.NSTATES(8), .SYNC_STAGES(2)) u_dut8 (
    .clk      (clk),
    .nclr     (nclr),
    .run_sw   (run8),
    .stop_sw  (stop8),
    .step_sw  (step8),
    .halt_req (halt8),
    .tstate   (ts8),
    .adv      (adv8),
    .cycle_end(ce8),
    .running  (rn8)
  );

  educ8_tstate_seq #(.NSTATES(5), .SYNC_STAGES(2)) u_dut5 (
    .clk      (clk),
    .nclr     (nclr),
    .run_sw   (run5),
    .stop_sw  (stop5),
    .step_sw  (step5),
    .halt_req (halt5),
    .tstate   (ts5),
    .adv      (adv5),
    .cycle_end(ce5),
    .running  (rn5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic run;
    logic stop;
    int   ts;
    logic adv;
    logic ce;
    logic rn;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic r, input logic s, input int ts, input logic a,
                      input logic c, input logic rn);
    vec_t v;
    v.run = r; v.stop = s; v.ts = ts; v.adv = a; v.ce = c; v.rn = rn;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Five-state instance in RUN: check one clock against the tracked T-state.
  int exp5;
  task automatic track5(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s ts5", tag), int'(ts5), exp5);
      chk($sformatf("%s ce5", tag), int'(ce5), (exp5 == 4) ? 1 : 0);
      chk($sformatf("%s running5", tag), int'(rn5), 1);
      exp5 = (exp5 + 1) % 5;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int n_adv;
    int n_ce;

    checks = 0;
    errors = 0;
    nclr = 1'b0;
    {run8, stop8, step8, halt8} = '0;
    {run5, stop5, step5, halt5} = '0;

    // Free run from RUN edge, then STOP while at T2.
    for (int i = 0; i < 2; i++) addv(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) addv(1, 0, i, 1, (i == 7) ? 1'b1 : 1'b0, 1);
    for (int i = 0; i < 3; i++) addv(1, 0, i, 1, 0, 1);
    for (int i = 3; i < 8; i++) addv(1, 1, i, 1, (i == 7) ? 1'b1 : 1'b0, 1);
    for (int i = 0; i < 2; i++) addv(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) addv(0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset ts8", int'(ts8), 0);
    chk("reset adv8", int'(adv8), 0);
    chk("reset ce8", int'(ce8), 0);
    chk("reset running8", int'(rn8), 0);
    chk("reset running5", int'(rn5), 0);
    nclr = 1'b1;
    @(negedge clk);

    // Table: free run and stop on boundary
    n_ce = 0;
    for (int i = 0; i < vq.size(); i++) begin
      run8  = vq[i].run;
      stop8 = vq[i].stop;
      @(negedge clk);
      chk($sformatf("vec%0d ts8", i), int'(ts8), vq[i].ts);
      chk($sformatf("vec%0d adv8", i), int'(adv8), int'(vq[i].adv));
      chk($sformatf("vec%0d ce8", i), int'(ce8), int'(vq[i].ce));
      chk($sformatf("vec%0d running8", i), int'(rn8), int'(vq[i].rn));
      if (vq[i].stop && ce8) n_ce++;
    end
    chk("cycle_end count after stop", n_ce, 1);

    // Single step, hold, release and re-press
    for (int p = 0; p < 2; p++) begin
      step8 = 1'b1;
      repeat (3) @(negedge clk);
      n_adv = 0;
      n_ce  = 0;
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("step%0d ts8", p), int'(ts8), k);
        if (adv8) n_adv++;
        if (ce8) n_ce++;
        @(negedge clk);
      end
      chk($sformatf("step%0d adv count", p), n_adv, 8);
      chk($sformatf("step%0d cycle_end count", p), n_ce, 1);
      chk($sformatf("step%0d halted ts8", p), int'(ts8), 0);
      chk($sformatf("step%0d halted running8", p), int'(rn8), 0);
      n_adv = 0;
      for (int k = 0; k < 10; k++) begin
        if (adv8) n_adv++;
        @(negedge clk);
      end
      chk($sformatf("step%0d held no retrigger", p), n_adv, 0);
      step8 = 1'b0;
      repeat (4) @(negedge clk);
    end

    // CPU halt: ignored at T3, honoured at T7
    run8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt run entry adv8", int'(adv8), 1);
    chk("halt run entry ts8", int'(ts8), 0);
    run8 = 1'b0;
    n = 0;
    while (ts8 != 4'd3 && n < 20) begin @(negedge clk); n++; end
    chk("wait ts8=3 in budget", (n < 20) ? 1 : 0, 1);
    halt8 = 1'b1;
    @(negedge clk);
    halt8 = 1'b0;
    chk("halt_req at T3 ts8", int'(ts8), 4);
    chk("halt_req at T3 running8", int'(rn8), 1);
    n = 0;
    while (ts8 != 4'd7 && n < 20) begin @(negedge clk); n++; end
    chk("wait ts8=7 in budget", (n < 20) ? 1 : 0, 1);
    halt8 = 1'b1;
    @(negedge clk);
    halt8 = 1'b0;
    chk("halt_req at T7 ts8", int'(ts8), 0);
    chk("halt_req at T7 running8", int'(rn8), 0);
    chk("halt_req at T7 adv8", int'(adv8), 0);
    @(negedge clk);
    chk("halt_req stays halted", int'(rn8), 0);

    // NSTATES=5: simultaneous run+step picks RUN
    run5  = 1'b1;
    step5 = 1'b1;
    repeat (3) @(negedge clk);
    exp5 = 0;
    track5(12, "run+step");
    run5  = 1'b0;
    step5 = 1'b0;
    track5(4, "release");
    step5 = 1'b1;
    track5(8, "step in run");
    stop5 = 1'b1;
    n = 0;
    while (rn5 && n < 20) begin @(negedge clk); n++; end
    chk("stop5 in budget", (n < 20) ? 1 : 0, 1);
    chk("stop5 halted ts5", int'(ts5), 0);
    stop5 = 1'b0;
    step5 = 1'b0;
    repeat (4) @(negedge clk);
    stop5 = 1'b1;
    repeat (6) @(negedge clk);
    chk("stop in halt running5", int'(rn5), 0);
    chk("stop in halt ts5", int'(ts5), 0);
    chk("stop in halt adv5", int'(adv5), 0);
    stop5 = 1'b0;

    // Reset mid-cycle at T5
    run8 = 1'b1;
    n = 0;
    while (ts8 != 4'd5 && n < 20) begin @(negedge clk); n++; end
    chk("wait ts8=5 in budget", (n < 20) ? 1 : 0, 1);
    chk("pre-reset running8", int'(rn8), 1);
    #2;
    nclr = 1'b0;
    run8 = 1'b0;
    #1;
    chk("async reset ts8", int'(ts8), 0);
    chk("async reset running8", int'(rn8), 0);
    chk("async reset adv8", int'(adv8), 0);
    chk("async reset ce8", int'(ce8), 0);
    #4;
    nclr = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("post-reset no completion ts8", int'(ts8), 0);
    chk("post-reset running8", int'(rn8), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
